// File: rtl/sync_fifo.sv
// Synchronous valid/ready FIFO with flush and occupancy status.
// Define FIFO_BYPASS_EN to let a word pass straight through an empty FIFO in the same cycle.
module sync_fifo #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AF_LEVEL  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_SIZE-1:0]       in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_SIZE-1:0]       out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic                 push, pop, wr_en, rd_en, bypass_take;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count       = wr_ptr_q - rd_ptr_q;
        almost_full = (count >= PW'(AF_LEVEL));
        in_ready    = !full && !flush;
        push        = in_valid && in_ready;
`ifdef FIFO_BYPASS_EN
        out_valid   = !flush && (!empty || in_valid);
        out_data    = empty ? in_data : mem[rd_ptr_q[AW-1:0]];
`else
        out_valid   = !empty && !flush;
        out_data    = mem[rd_ptr_q[AW-1:0]];
`endif
        pop         = out_valid && out_ready;
        // An empty-FIFO pop can only be a pass-through word; it never touches storage.
        bypass_take = empty && pop;
        wr_en       = push && !bypass_take;
        rd_en       = pop && !empty;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            rd_ptr_q <= wr_ptr_q;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem[wr_ptr_q[AW-1:0]] <= in_data;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (count <= PW'(DEPTH)) else $error("sync_fifo occupancy above DEPTH");
        end
    end
`endif

endmodule
